// File: rtl/uart_led_cmd.sv
// uart_led_cmd: byte command processor sitting between a UART byte interface
// and a bank of LEDs. Commands set the LED pattern, PWM brightness and blink
// period, a query reports the pattern, and every command is answered on TX.

module uart_led_cmd #(
   parameter int NUM_LEDS       = 6,
   parameter int PWM_PRESCALE   = 105,
   parameter int BLINK_TICK     = 27000,
   parameter int TIMEOUT_CYCLES = 2700000,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                rx_byte_ready_i,
   input  logic [7:0]          rx_data_i,
   output logic [7:0]          tx_data_o,
   output logic                tx_trigger_o,
   input  logic                tx_complete_i,
   output logic [NUM_LEDS-1:0] led_o,
   output logic                cmd_err_o,
   output logic [1:0]          parse_state_o
);

   localparam int PSC_W  = $clog2(PWM_PRESCALE + 1);
   localparam int TICK_W = $clog2(BLINK_TICK + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(PWM_PRESCALE - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICK - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [NUM_LEDS-1:0] LED_OFF = LED_ACTIVE_LOW ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

   localparam logic [7:0] OP_LED   = 8'h4C;
   localparam logic [7:0] OP_BRIGHT = 8'h42;
   localparam logic [7:0] OP_BLINK = 8'h4B;
   localparam logic [7:0] OP_QUERY = 8'h3F;
   localparam logic [7:0] RESP_ACK = 8'h06;
   localparam logic [7:0] RESP_NAK = 8'h15;

   typedef enum logic [1:0] {P_IDLE = 2'd0, P_WAIT_ARG = 2'd1} parse_t;
   typedef enum logic [1:0] {TX_IDLE, TX_WAIT_LOW, TX_WAIT_HIGH} tx_t;

   parse_t parse_state, parse_next;
   tx_t    tx_state, tx_next;

   logic [7:0]          opcode;
   logic [TO_W-1:0]     timeout_cnt;
   logic [NUM_LEDS-1:0] pattern;
   logic [7:0]          brightness;
   logic [7:0]          blink_period;
   logic                blink_phase;
   logic [7:0]          blink_cnt;
   logic [TICK_W-1:0]   tick_cnt;
   logic [PSC_W-1:0]    psc_cnt;
   logic [7:0]          pwm_cnt;
   logic                pending;
   logic [7:0]          pending_data;

   logic                resp_valid, apply_op, timeout_hit, query_hit, tx_fire;
   logic [7:0]          resp_data;
   logic                blink_restart, tick, pwm_on;
   logic [NUM_LEDS-1:0] lit;

   assign parse_state_o = parse_state;
   assign blink_restart = apply_op && (opcode == OP_BLINK);
   assign tick          = (tick_cnt == TICK_LAST);
   assign pwm_on        = (pwm_cnt < brightness) || (brightness == 8'hFF);
   assign lit           = pattern & {NUM_LEDS{pwm_on & blink_phase}};

   // Both FSM state registers; a reset abandons any partial command or transmit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         parse_state <= P_IDLE;
         tx_state    <= TX_IDLE;
      end else begin
         parse_state <= parse_next;
         tx_state    <= tx_next;
      end
   end

   // Parser decisions: operands are never decoded as opcodes, and a byte that
   // lands on the timeout cycle still wins over the timeout.
   always_comb begin
      parse_next  = parse_state;
      resp_valid  = 1'b0;
      resp_data   = 8'h00;
      apply_op    = 1'b0;
      timeout_hit = 1'b0;
      query_hit   = 1'b0;
      case (parse_state)
         P_IDLE: begin
            if (rx_byte_ready_i) begin
               if (rx_data_i == OP_LED || rx_data_i == OP_BRIGHT || rx_data_i == OP_BLINK) begin
                  parse_next = P_WAIT_ARG;
               end else if (rx_data_i == OP_QUERY) begin
                  resp_valid = 1'b1;
                  resp_data  = 8'(pattern);
                  query_hit  = 1'b1;
               end else begin
                  resp_valid = 1'b1;
                  resp_data  = RESP_NAK;
               end
            end
         end
         P_WAIT_ARG: begin
            if (rx_byte_ready_i) begin
               apply_op   = 1'b1;
               resp_valid = 1'b1;
               resp_data  = RESP_ACK;
               parse_next = P_IDLE;
            end else if (timeout_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               parse_next  = P_IDLE;
            end
         end
         default: parse_next = P_IDLE;
      endcase
   end

   // Transmit handshake: hand over the pending byte when the UART is idle, then
   // wait for its busy period (complete low, then high again) to finish.
   always_comb begin
      tx_next = tx_state;
      tx_fire = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (pending && tx_complete_i) begin
               tx_fire = 1'b1;
               tx_next = TX_WAIT_LOW;
            end
         end
         TX_WAIT_LOW:  if (!tx_complete_i) tx_next = TX_WAIT_HIGH;
         TX_WAIT_HIGH: if (tx_complete_i) tx_next = TX_IDLE;
         default:      tx_next = TX_IDLE;
      endcase
   end

   // Remember the opcode and count idle cycles while waiting for its operand.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opcode      <= 8'h00;
         timeout_cnt <= '0;
      end else if (parse_state == P_IDLE) begin
         timeout_cnt <= '0;
         if (rx_byte_ready_i) opcode <= rx_data_i;
      end else begin
         timeout_cnt <= timeout_cnt + TO_W'(1);
      end
   end

   // Configuration registers written by completed two-byte commands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pattern      <= '0;
         brightness   <= 8'hFF;
         blink_period <= 8'h00;
      end else if (apply_op) begin
         case (opcode)
            OP_LED:    pattern      <= rx_data_i[NUM_LEDS-1:0];
            OP_BRIGHT: brightness   <= rx_data_i;
            OP_BLINK:  blink_period <= rx_data_i;
            default:   pattern      <= pattern;
         endcase
      end
   end

   // One-deep response slot plus the TX byte/strobe; a response that finds the
   // slot still occupied is dropped and flagged, and the flag wins over a query.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending      <= 1'b0;
         pending_data <= 8'h00;
         tx_data_o    <= 8'h00;
         tx_trigger_o <= 1'b0;
         cmd_err_o    <= 1'b0;
      end else begin
         tx_trigger_o <= tx_fire;
         if (tx_fire) tx_data_o <= pending_data;
         if (resp_valid && (!pending || tx_fire)) begin
            pending      <= 1'b1;
            pending_data <= resp_data;
         end else if (tx_fire) begin
            pending <= 1'b0;
         end
         if (timeout_hit || (resp_valid && pending && !tx_fire)) begin
            cmd_err_o <= 1'b1;
         end else if (query_hit) begin
            cmd_err_o <= 1'b0;
         end
      end
   end

   // Free-running PWM ramp, advanced once per prescale period.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         psc_cnt <= '0;
         pwm_cnt <= 8'h00;
      end else if (psc_cnt == PSC_LAST) begin
         psc_cnt <= '0;
         pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
         psc_cnt <= psc_cnt + PSC_W'(1);
      end
   end

   // Blink timebase; a new blink command restarts it so the first lit half is full length.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_cnt    <= '0;
         blink_cnt   <= 8'h00;
         blink_phase <= 1'b1;
      end else if (blink_restart) begin
         tick_cnt    <= '0;
         blink_cnt   <= 8'h00;
         blink_phase <= 1'b1;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
         if (blink_period == 8'h00) begin
            blink_cnt   <= 8'h00;
            blink_phase <= 1'b1;
         end else if (tick) begin
            if (blink_cnt == blink_period - 8'd1) begin
               blink_cnt   <= 8'h00;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 8'd1;
            end
         end
      end
   end

   // Registered LED drive with optional inversion for active-low boards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         led_o <= LED_OFF;
      end else begin
         led_o <= LED_ACTIVE_LOW ? ~lit : lit;
      end
   end

endmodule

// File: doc/uart_led_cmd.md
Name: uart_led_cmd

Overview:
Byte-level command processor between the `uart` core's RX/TX byte interface and a parametrised LED bank. It generalises the "last received byte on LEDs" top level:
- Two-byte commands set the LED pattern, PWM brightness and blink period.
- A query returns the current pattern.
- Every command is acknowledged over UART TX.
- An inter-byte timeout recovers the parser from partial commands.

Parameters:
NUM_LEDS, 6, LED count (1..8); pattern uses bits [NUM_LEDS-1:0] of operand
PWM_PRESCALE, 105, clk cycles per PWM counter step (27 MHz/105/256 ≈ 1 kHz PWM)
BLINK_TICK, 27000, clk cycles per blink tick (1 ms at 27 MHz)
TIMEOUT_CYCLES, 2700000, max cycles between opcode and operand (100 ms)
LED_ACTIVE_LOW, 1, 1 = led_o inverted (LED lit when bit is 0)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
rx_byte_ready_i  in  1  one-cycle pulse, rx_data_i valid
rx_data_i  in  8  received byte
tx_data_o  out  8  byte to transmit, stable from trigger until tx_complete_i returns high
tx_trigger_o  out  1  one-cycle transmit request
tx_complete_i  in  1  high = transmitter idle
led_o  out  NUM_LEDS  registered LED drive
cmd_err_o  out  1  sticky error flag
parse_state_o  out  2  debug: 0 IDLE, 1 WAIT_ARG

Behaviour:
Reset (async, all regs):
- pattern=0, brightness=8'hFF, blink_period=0, blink_phase=1.
- led_o = all LEDs off (all 1s if LED_ACTIVE_LOW).
- tx_data_o=0, tx_trigger_o=0, cmd_err_o=0, no response pending, parser IDLE.
- Reset mid-command or mid-transmit discards everything.

Command set (opcode, then operand where required):
- 'L' 0x4C + v: pattern <= v[NUM_LEDS-1:0]; response ACK 0x06.
- 'B' 0x42 + v: brightness <= v; response 0x06.
- 'K' 0x4B + v: blink_period <= v (ticks); 0 = steady; blink counters and phase restart (phase=1); response 0x06.
- '?' 0x3F, no operand: response = {0, pattern}; also clears cmd_err_o.
- Any other byte in IDLE: response NAK 0x15; stay IDLE.

Parser FSM:
- IDLE --L/B/K--> WAIT_ARG, timeout counter cleared.
- WAIT_ARG --byte--> apply on the next clock, queue response, go IDLE.
- WAIT_ARG with timeout counter reaching TIMEOUT_CYCLES-1 with no byte -> IDLE, cmd_err_o<=1, no response.
- A byte arriving in the same cycle as timeout expiry counts as the operand; timeout is ignored.
- Operand bytes are never interpreted as opcodes.

Response path (one-deep pending register):
- TX_IDLE: when pending and tx_complete_i=1, assert tx_trigger_o for exactly one cycle with tx_data_o=pending byte -> TX_WAIT.
- TX_WAIT: wait for tx_complete_i=0, then wait for it to return to 1 -> TX_IDLE.
- A new response while one is already pending and not yet triggered is dropped; cmd_err_o<=1.
- A response generated while in TX_WAIT becomes pending normally.

Latency:
- Register update 1 cycle after the operand pulse.
- led_o reflects the change 2 cycles after the operand pulse, subject to PWM and blink phase.
- tx_trigger_o at the earliest 2 cycles after the completing byte.

PWM:
- 8-bit pwm_cnt increments every PWM_PRESCALE clocks and wraps 255->0.
- pwm_on = (pwm_cnt < brightness) | (brightness == 255).
- brightness=0 means always dark.

Blink:
- tick_cnt wraps at BLINK_TICK-1 and produces a tick.
- blink_cnt counts ticks; when it reaches blink_period-1, blink_phase toggles and blink_cnt clears.
- blink_period=0 forces blink_phase=1.

LED drive:
- lit[i] = pattern[i] & pwm_on & blink_phase.
- led_o <= LED_ACTIVE_LOW ? ~lit : lit (registered).

Test Plan:
(Bench overrides: PWM_PRESCALE=1, BLINK_TICK=4, TIMEOUT_CYCLES=50, NUM_LEDS=6, LED_ACTIVE_LOW=1; TX model holds tx_complete_i low 20 cycles after each trigger.)
1. Reset release -> led_o=6'b111111, tx_trigger_o=0, cmd_err_o=0; then bytes 0x4C,0x2A -> led_o=6'b010101 within 2 cycles; one tx_trigger_o pulse with tx_data_o=0x06.
2. 'L',0x3F then 'B',0x40 -> over 256 cycles each LED is active (0) for exactly 64 cycles; 'B',0x00 -> led_o stays 6'b111111; 'B',0xFF -> continuously 6'b000000.
3. 'L',0x01 then 'K',0x02 -> led_o[0] toggles every 8 cycles; 'K',0x00 -> steady lit; two 0x06 responses.
4. 0x4C, then 60 idle cycles, then 0x2A -> no pattern change, cmd_err_o=1 after cycle 50, 0x2A answered with NAK 0x15; then '?' -> response 0x00, cmd_err_o=0.
5. Bytes 0x99, 0x98, 0x97 back-to-back, 3 cycles apart, while TX busy -> first transmitted as 0x15, second pending and transmitted after tx_complete_i recovers, third dropped with cmd_err_o=1; exactly 2 trigger pulses.
6. Assert rst_i in WAIT_ARG and during TX_WAIT -> all outputs return to reset values immediately; subsequent 0x2A treated as opcode (NAK), not operand.
